// File: rtl/dpram_rr_arbiter_if.sv
// rtl/dpram_rr_arbiter_if.sv - requester-side command/response bundle for the RAM port A arbiter
// master = requesting engines, slave = arbiter.
interface dpram_rr_arbiter_if #(
  parameter int N_REQ   = 4,
  parameter int AW      = 10,
  parameter int D_WIDTH = 8,
  parameter int IW      = 2
) ();
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_we;
  logic [N_REQ*AW-1:0]      req_addr;
  logic [N_REQ*D_WIDTH-1:0] req_wdata;
  logic [N_REQ-1:0]         req_ready;
  logic                     rsp_valid;
  logic [IW-1:0]            rsp_id;
  logic [D_WIDTH-1:0]       rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_id, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_id, rsp_rdata
  );
endinterface

// File: rtl/dpram_rr_arbiter.sv
// rtl/dpram_rr_arbiter.sv - round-robin arbiter sharing RAM port A between N_REQ requesters
// One command per cycle is registered onto the RAM; reads return ID-tagged data 2 cycles later.
module dpram_rr_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DEPTH   = 1024,
  parameter int D_WIDTH = 8,
  localparam int AW     = $clog2(DEPTH),
  localparam int IW     = $clog2(N_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  dpram_rr_arbiter_if.slave  bus,
  output logic               o_ram_we,
  output logic [AW-1:0]      o_ram_addr,
  output logic [D_WIDTH-1:0] o_ram_din,
  input  logic [D_WIDTH-1:0] i_ram_dout
);

  localparam logic [IW:0]   N_W  = (IW+1)'(N_REQ);
  localparam logic [IW-1:0] LAST = IW'(N_REQ-1);

  logic [IW-1:0]      r_ptr;
  logic               r_ram_we;
  logic [AW-1:0]      r_ram_addr;
  logic [D_WIDTH-1:0] r_ram_din;
  logic               r_s1_rd;
  logic [IW-1:0]      r_s1_id;
  logic               r_s2_rd;
  logic [IW-1:0]      r_s2_id;

  logic               w_hs;
  logic [IW-1:0]      w_gnt;
  logic [IW:0]        w_scan;
  logic [N_REQ-1:0]   w_ready;
  logic [IW-1:0]      w_ptr_nxt;
  logic               w_we;
  logic [AW-1:0]      w_addr;
  logic [D_WIDTH-1:0] w_wdata;

  // Scan from ptr upward with explicit wrap so non-power-of-two N_REQ works.
  always_comb begin
    w_hs   = 1'b0;
    w_gnt  = '0;
    w_scan = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_scan = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_scan >= N_W) begin
        w_scan = w_scan - N_W;
      end
      if (!w_hs && bus.req_valid[w_scan[IW-1:0]]) begin
        w_hs  = 1'b1;
        w_gnt = w_scan[IW-1:0];
      end
    end
    if (i_rst) begin
      w_hs = 1'b0;
    end
  end

  always_comb begin
    w_ready = '0;
    if (w_hs) begin
      w_ready[w_gnt] = 1'b1;
    end
  end

  always_comb begin
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt == IW'(i)) begin
        w_we    = bus.req_we[i];
        w_addr  = bus.req_addr[i*AW +: AW];
        w_wdata = bus.req_wdata[i*D_WIDTH +: D_WIDTH];
      end
    end
  end

  assign w_ptr_nxt = (w_gnt == LAST) ? '0 : w_gnt + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr      <= '0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_s1_rd    <= 1'b0;
      r_s1_id    <= '0;
      r_s2_rd    <= 1'b0;
      r_s2_id    <= '0;
    end else begin
      if (w_hs) begin
        r_ptr      <= w_ptr_nxt;
        r_ram_we   <= w_we;
        r_ram_addr <= w_addr;
        r_ram_din  <= w_wdata;
        r_s1_id    <= w_gnt;
      end else begin
        r_ram_we   <= 1'b0;
      end
      // Stage 2 lines up with the RAM's registered read data.
      r_s1_rd <= w_hs & ~w_we;
      r_s2_rd <= r_s1_rd;
      r_s2_id <= r_s1_id;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_s2_rd;
  assign bus.rsp_id    = r_s2_id;
  assign bus.rsp_rdata = i_ram_dout;
  assign o_ram_we      = r_ram_we;
  assign o_ram_addr    = r_ram_addr;
  assign o_ram_din     = r_ram_din;

endmodule

// File: tb/tb_dpram_rr_arbiter.sv
// tb/tb_dpram_rr_arbiter.sv - directed self-checking bench for dpram_rr_arbiter
// A behavioural RAM preloaded with mem[a] = a[7:0] ^ 8'h5A sits on port A.
module tb_dpram_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ram_we;
  logic [9:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic [7:0] mem [1024];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dpram_rr_arbiter_if #(.N_REQ(4), .AW(10), .D_WIDTH(8), .IW(2)) bus ();

  dpram_rr_arbiter #(.N_REQ(4), .DEPTH(1024), .D_WIDTH(8)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .bus        (bus),
    .o_ram_we   (ram_we),
    .o_ram_addr (ram_addr),
    .o_ram_din  (ram_din),
    .i_ram_dout (ram_dout)
  );

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = i[7:0] ^ 8'h5A;
  end

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int i, input logic we, input logic [9:0] addr, input logic [7:0] wd);
    bus.req_we[i]           = we;
    bus.req_addr[i*10 +: 10] = addr;
    bus.req_wdata[i*8 +: 8]  = wd;
  endtask

  // Drive valids for one cycle, check grant and the response visible in that cycle.
  task automatic step(input string tag, input logic [3:0] v, input logic [3:0] rdy,
                      input logic rv, input logic [1:0] id, input logic [7:0] d);
    bus.req_valid = v;
    #1;
    check({tag, ".rdy"}, 32'(bus.req_ready), 32'(rdy));
    check({tag, ".rv"}, 32'(bus.rsp_valid), 32'(rv));
    if (rv) begin
      check({tag, ".id"}, 32'(bus.rsp_id), 32'(id));
      check({tag, ".data"}, 32'(bus.rsp_rdata), 32'(d));
    end
    tick();
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus.req_valid = 4'hF;
    #1;
    check({tag, ".rdy_in_rst"}, 32'(bus.req_ready), 32'h0);
    tick();
    tick();
    check({tag, ".ram_we"}, 32'(ram_we), 32'h0);
    check({tag, ".ram_addr"}, 32'(ram_addr), 32'h0);
    check({tag, ".ram_din"}, 32'(ram_din), 32'h0);
    check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
    check({tag, ".rsp_id"}, 32'(bus.rsp_id), 32'h0);
    rst = 1'b0;
    bus.req_valid = 4'h0;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    tick();
    do_reset("rst0");

    // Requester 0: write then read back.
    set_cmd(0, 1'b1, 10'h010, 8'hA5);
    step("t1.wr", 4'b0001, 4'b0001, 1'b0, 2'd0, 8'h00);
    check("t1.ram_we", 32'(ram_we), 32'h1);
    check("t1.ram_addr", 32'(ram_addr), 32'h010);
    check("t1.ram_din", 32'(ram_din), 32'hA5);
    set_cmd(0, 1'b0, 10'h010, 8'h00);
    step("t1.rd", 4'b0001, 4'b0001, 1'b0, 2'd0, 8'h00);
    check("t1.ram_we_rd", 32'(ram_we), 32'h0);
    step("t1.w1", 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00);
    step("t1.w2", 4'b0000, 4'b0000, 1'b1, 2'd0, 8'hA5);
    step("t1.w3", 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00);

    // All four reading continuously from ptr=0.
    do_reset("rst1");
    for (int i = 0; i < 4; i++) set_cmd(i, 1'b0, 10'h100 + 10'(i), 8'h00);
    for (int k = 0; k < 8; k++) begin
      logic [3:0] v;
      logic [3:0] r;
      logic [1:0] id;
      v  = (k < 6) ? 4'hF : 4'h0;
      r  = (k < 6) ? (4'b0001 << (k % 4)) : 4'b0000;
      id = 2'((k + 2) % 4);
      step($sformatf("t2.c%0d", k), v, r, k >= 2, id, {6'b0, id} ^ 8'h5A);
    end

    // ptr=2 with only 0 and 3 valid: wrap-around.
    step("t3.c0", 4'b1001, 4'b1000, 1'b0, 2'd0, 8'h00);
    step("t3.c1", 4'b1001, 4'b0001, 1'b0, 2'd0, 8'h00);
    step("t3.c2", 4'b0000, 4'b0000, 1'b1, 2'd3, 8'h59);
    step("t3.c3", 4'b0000, 4'b0000, 1'b1, 2'd0, 8'h5A);
    step("t3.c4", 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00);

    // Write by 1 then read of the same address by 2 on the next cycle.
    set_cmd(1, 1'b1, 10'h3FF, 8'h3C);
    set_cmd(2, 1'b0, 10'h3FF, 8'h00);
    step("t4.wr", 4'b0010, 4'b0010, 1'b0, 2'd0, 8'h00);
    set_cmd(1, 1'b0, 10'h102, 8'h00);
    step("t4.rd", 4'b0100, 4'b0100, 1'b0, 2'd0, 8'h00);
    step("t4.c2", 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00);
    step("t4.c3", 4'b0000, 4'b0000, 1'b1, 2'd2, 8'h3C);
    step("t4.c4", 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00);

    // Reset one cycle after a read handshake drops the response.
    set_cmd(0, 1'b0, 10'h105, 8'h00);
    step("t5.rd", 4'b0001, 4'b0001, 1'b0, 2'd0, 8'h00);
    rst = 1'b1;
    step("t5.rst", 4'b0001, 4'b0000, 1'b0, 2'd0, 8'h00);
    rst = 1'b0;
    step("t5.c2", 4'b1110, 4'b0010, 1'b0, 2'd0, 8'h00);
    step("t5.c3", 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00);
    step("t5.c4", 4'b0000, 4'b0000, 1'b1, 2'd1, 8'h58);
    step("t5.c5", 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00);

    // Requester 2 withdraws while requester 0 streams.
    set_cmd(2, 1'b1, 10'h200, 8'h77);
    step("t6.c0", 4'b0100, 4'b0100, 1'b0, 2'd0, 8'h00);
    set_cmd(2, 1'b0, 10'h200, 8'h00);
    set_cmd(0, 1'b0, 10'h106, 8'h00);
    step("t6.c1", 4'b0101, 4'b0001, 1'b0, 2'd0, 8'h00);
    step("t6.c2", 4'b0001, 4'b0001, 1'b0, 2'd0, 8'h00);
    step("t6.c3", 4'b0001, 4'b0001, 1'b1, 2'd0, 8'h5C);
    step("t6.c4", 4'b0000, 4'b0000, 1'b1, 2'd0, 8'h5C);
    step("t6.c5", 4'b0110, 4'b0010, 1'b1, 2'd0, 8'h5C);
    step("t6.c6", 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00);
    step("t6.c7", 4'b0000, 4'b0000, 1'b1, 2'd1, 8'h58);
    step("t6.c8", 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
